// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Bus bundle between mem_wb_stage and its neighbours: the data-memory
//   req/ack channel and the register-file write-back valid/ready channel.
//   master : the stage side (drives mem_req/we/addr/wdata, wb_valid/idx/data)
//   slave  : memory + register-file side (drives mem_ack/rdata, wb_ready)
interface mem_wb_stage_if #(
   parameter int RAW = 3
);
   logic           mem_req;
   logic           mem_we;
   logic [7:0]     mem_addr;
   logic [7:0]     mem_wdata;
   logic           mem_ack;
   logic [7:0]     mem_rdata;
   logic           wb_valid;
   logic           wb_ready;
   logic [RAW-1:0] wb_idx;
   logic [7:0]     wb_data;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output wb_valid, wb_idx, wb_data,
      input  wb_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  wb_valid, wb_idx, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Stage downstream of the X9 ALU. Registers each ALU result, runs lb/sb
//   data-memory accesses over a variable-latency req/ack handshake, presents
//   register write-back with valid/ready and holds the shift/carry flag that
//   feeds the ALU sc_i input.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   ALU op handshake
//   alu_cmd, alu_rslt   opcode (0011=lb, 0100=sb) and result / memory address
//   alu_sc              ALU shift/carry out
//   st_data             store data for sb
//   rd_idx, wb_en_in    destination register and its write enable
//   bus (master)        memory req/ack channel and write-back valid/ready channel
//   sc_flag             registered shift/carry flag
//   timeout_err         sticky memory timeout (MEM_TIMEOUT_EN only)
// Configuration
//   MEM_TIMEOUT_EN      when defined, a MEM access without mem_ack for
//                       TIMEOUT_CYC cycles is aborted and timeout_err is set.
module mem_wb_stage #(
   parameter int RAW         = 3,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     alu_cmd,
   input  logic [7:0]     alu_rslt,
   input  logic           alu_sc,
   input  logic [7:0]     st_data,
   input  logic [RAW-1:0] rd_idx,
   input  logic           wb_en_in,
   mem_wb_stage_if.master bus,
   output logic           sc_flag
`ifdef MEM_TIMEOUT_EN
   ,
   output logic           timeout_err
`endif
);

   localparam logic [3:0] CMD_ADD  = 4'b0000;
   localparam logic [3:0] CMD_SUB  = 4'b0001;
   localparam logic [3:0] CMD_ADDI = 4'b0010;
   localparam logic [3:0] CMD_LB   = 4'b0011;
   localparam logic [3:0] CMD_SB   = 4'b0100;
   localparam logic [3:0] CMD_SLL  = 4'b1011;
   localparam logic [3:0] CMD_SLR  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t         state, state_nxt;

   logic [7:0]     addr_q;
   logic [7:0]     wdata_q;
   logic           we_q;
   logic [RAW-1:0] idx_q;
   logic [7:0]     data_q;

   logic accept;
   logic is_mem;
   logic sc_upd;
   logic abort;

   assign in_ready = (state == IDLE) && rst_n;
   assign accept   = in_valid && in_ready;
   assign is_mem   = (alu_cmd == CMD_LB) || (alu_cmd == CMD_SB);
   assign sc_upd   = (alu_cmd == CMD_ADD) || (alu_cmd == CMD_SUB) ||
                     (alu_cmd == CMD_ADDI) || (alu_cmd == CMD_SLL) ||
                     (alu_cmd == CMD_SLR);

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tmo_cnt;

   // Counter sits at zero outside MEM, so it is clear on every MEM entry.
   // A cycle with mem_ack always wins over the abort.
   assign abort = (state == MEM) && !bus.mem_ack &&
                  (tmo_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == MEM)
            tmo_cnt <= tmo_cnt + 1'b1;
         else
            tmo_cnt <= '0;
         if (abort)
            timeout_err <= 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_mem)
                  state_nxt = MEM;
               else if (wb_en_in)
                  state_nxt = WB;
            end
         end
         MEM: begin
            if (bus.mem_ack || abort)
               state_nxt = we_q ? IDLE : WB;
         end
         WB: begin
            if (bus.wb_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         sc_flag <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= alu_rslt;
            wdata_q <= st_data;
            we_q    <= (alu_cmd == CMD_SB);
            idx_q   <= rd_idx;
            if (!is_mem)
               data_q <= alu_rslt;
            if (sc_upd)
               sc_flag <= alu_sc;
         end
         if ((state == MEM) && !we_q) begin
            if (bus.mem_ack)
               data_q <= bus.mem_rdata;
            else if (abort)
               data_q <= '0;
         end
      end
   end

   assign bus.mem_req   = (state == MEM);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.wb_valid  = (state == WB);
   assign bus.wb_idx    = idx_q;
   assign bus.wb_data   = data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. Inputs are driven and outputs observed
//   on the falling clock edge; expected values are hand-computed constants.
module tb_mem_wb_stage;

   localparam int RAW = 3;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     alu_cmd;
   logic [7:0]     alu_rslt;
   logic           alu_sc;
   logic [7:0]     st_data;
   logic [RAW-1:0] rd_idx;
   logic           wb_en_in;
   logic           sc_flag;
`ifdef MEM_TIMEOUT_EN
   logic           timeout_err;
`endif

   int total;
   int bad;

   mem_wb_stage_if #(.RAW(RAW)) bus ();

   mem_wb_stage #(
      .RAW         (RAW),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_cmd     (alu_cmd),
      .alu_rslt    (alu_rslt),
      .alu_sc      (alu_sc),
      .st_data     (st_data),
      .rd_idx      (rd_idx),
      .wb_en_in    (wb_en_in),
      .bus         (bus.master),
      .sc_flag     (sc_flag)
`ifdef MEM_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one op for a single cycle.
   task automatic issue(input logic [3:0] cmd, input logic [7:0] rslt, input logic sc,
                        input logic [7:0] sd, input logic [RAW-1:0] rd, input logic wen);
      in_valid = 1'b1;
      alu_cmd  = cmd;
      alu_rslt = rslt;
      alu_sc   = sc;
      st_data  = sd;
      rd_idx   = rd;
      wb_en_in = wen;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      alu_cmd      = '0;
      alu_rslt     = '0;
      alu_sc       = 1'b0;
      st_data      = '0;
      rd_idx       = '0;
      wb_en_in     = 1'b0;
      bus.mem_ack  = 1'b0;
      bus.mem_rdata = '0;
      bus.wb_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_sc_flag", sc_flag, 0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1);

      // add, write-back next cycle
      tick();
      issue(4'b0000, 8'h2A, 1'b1, 8'h00, 3'd3, 1'b1);
      check("add_wb_valid", bus.wb_valid, 1);
      check("add_wb_idx", bus.wb_idx, 3);
      check("add_wb_data", bus.wb_data, 8'h2A);
      check("add_sc_flag", sc_flag, 1);
      check("add_in_ready", in_ready, 0);
      tick();
      check("add_done_valid", bus.wb_valid, 0);
      check("add_done_ready", in_ready, 1);

      // lb with ack on the third request cycle (wb_en_in=0 must still write)
      issue(4'b0011, 8'h10, 1'b0, 8'h00, 3'd5, 1'b0);
      check("lb_req1", bus.mem_req, 1);
      check("lb_we", bus.mem_we, 0);
      check("lb_addr", bus.mem_addr, 8'h10);
      tick();
      check("lb_req2", bus.mem_req, 1);
      tick();
      check("lb_req3", bus.mem_req, 1);
      check("lb_addr_held", bus.mem_addr, 8'h10);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'hC3;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      check("lb_req_drop", bus.mem_req, 0);
      check("lb_wb_valid", bus.wb_valid, 1);
      check("lb_wb_data", bus.wb_data, 8'hC3);
      check("lb_wb_idx", bus.wb_idx, 5);
      check("lb_sc_held", sc_flag, 1);
      tick();
      check("lb_idle", in_ready, 1);

      // Stray ack while idle is ignored
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("stray_ack_req", bus.mem_req, 0);
      check("stray_ack_wbv", bus.wb_valid, 0);
      check("stray_ack_rdy", in_ready, 1);

      // sb, no write-back even with wb_en_in=1
      issue(4'b0100, 8'h80, 1'b0, 8'h5A, 3'd2, 1'b1);
      check("sb_req", bus.mem_req, 1);
      check("sb_we", bus.mem_we, 1);
      check("sb_addr", bus.mem_addr, 8'h80);
      check("sb_wdata", bus.mem_wdata, 8'h5A);
      check("sb_in_ready", in_ready, 0);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("sb_req_drop", bus.mem_req, 0);
      check("sb_no_wb", bus.wb_valid, 0);
      check("sb_in_ready_back", in_ready, 1);

      // sub with stalled write-back, carry cleared
      bus.wb_ready = 1'b0;
      issue(4'b0001, 8'h7F, 1'b0, 8'h00, 3'd6, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("stall_valid", bus.wb_valid, 1);
         check("stall_idx", bus.wb_idx, 6);
         check("stall_data", bus.wb_data, 8'h7F);
         check("stall_in_ready", in_ready, 0);
         tick();
      end
      check("sub_sc_flag", sc_flag, 0);
      bus.wb_ready = 1'b1;
      tick();
      check("stall_release_valid", bus.wb_valid, 0);
      check("stall_release_ready", in_ready, 1);

      // Non-writing register op, opcode outside the carry set holds sc_flag
      issue(4'b0101, 8'h11, 1'b1, 8'h00, 3'd1, 1'b0);
      check("nowb_valid", bus.wb_valid, 0);
      check("nowb_ready", in_ready, 1);
      check("nowb_sc_held", sc_flag, 0);

      // sll with wb_en_in=0 still updates carry
      issue(4'b1011, 8'h22, 1'b1, 8'h00, 3'd1, 1'b0);
      check("sll_sc_flag", sc_flag, 1);
      check("sll_ready", in_ready, 1);

`ifdef MEM_TIMEOUT_EN
      // lb with no ack: aborted after 15 request cycles
      check("tmo_err_init", timeout_err, 0);
      issue(4'b0011, 8'h20, 1'b0, 8'h00, 3'd4, 1'b1);
      cnt = 0;
      while (bus.mem_req && cnt < 40) begin
         cnt++;
         tick();
      end
      check("tmo_req_cycles", cnt, 15);
      check("tmo_wb_valid", bus.wb_valid, 1);
      check("tmo_wb_data", bus.wb_data, 8'h00);
      check("tmo_err_set", timeout_err, 1);
      tick();
      tick();
      check("tmo_err_sticky", timeout_err, 1);
      check("tmo_idle", in_ready, 1);
`endif

      // Reset asserted in the middle of a memory access
      issue(4'b0011, 8'h44, 1'b0, 8'h00, 3'd7, 1'b1);
      check("mid_req_before", bus.mem_req, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", bus.mem_req, 0);
      check("mid_rst_wbv", bus.wb_valid, 0);
      check("mid_rst_sc", sc_flag, 0);
      check("mid_rst_ready", in_ready, 0);
`ifdef MEM_TIMEOUT_EN
      check("mid_rst_tmo", timeout_err, 0);
`endif
      tick();
      rst_n = 1'b1;
      #1;
      check("mid_rel_ready", in_ready, 1);
      tick();
      check("mid_rel_req", bus.mem_req, 0);
      check("mid_rel_wbv", bus.wb_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
